// File: rtl/packet_receiver_if.sv
// -----------------------------------------------------------------------------
// packet_receiver_if
//   Bundles the inter-board chunk link (4-phase REQ/ACK with a CHUNK_W data
//   bus) together with the reassembled-datagram output towards the renderer.
//
//   Signals:
//     req_in   : link REQ from the sender (asynchronous to the receiver clock)
//     data_in  : link data chunk, stable while REQ is high until ACK rises
//     ack_out  : link ACK back to the sender
//     data_out : last complete datagram
//     valid    : one-cycle strobe when data_out updates
//
//   Modports:
//     master : sender/consumer side (drives the link, observes the outputs)
//     slave  : receiver side (packet_receiver)
// -----------------------------------------------------------------------------
interface packet_receiver_if #(
  parameter int MSG_W   = 64,
  parameter int CHUNK_W = 6
);
  logic               req_in;
  logic [CHUNK_W-1:0] data_in;
  logic               ack_out;
  logic [MSG_W-1:0]   data_out;
  logic               valid;

  modport master (
    output req_in,
    output data_in,
    input  ack_out,
    input  data_out,
    input  valid
  );

  modport slave (
    input  req_in,
    input  data_in,
    output ack_out,
    output data_out,
    output valid
  );
endinterface

// File: rtl/packet_receiver.sv
// -----------------------------------------------------------------------------
// packet_receiver
//   Receive side of the inter-board link. Accepts CHUNK_W-bit chunks over a
//   4-phase REQ/ACK handshake, reassembles them LSB-first into an MSG_W-bit
//   datagram and publishes it on data_out with a one-cycle valid strobe.
//   A partial packet left idle for TIMEOUT cycles is discarded so framing
//   recovers; each discard bumps a saturating drop counter.
//
//   Ports:
//     clk      : system clock, the only clock
//     rst      : synchronous active-low reset
//     bus      : packet_receiver_if.slave (req_in, data_in, ack_out,
//                data_out, valid)
//     drop_cnt : saturating count of discarded partial packets
// -----------------------------------------------------------------------------
module packet_receiver #(
  parameter int MSG_W   = 64,
  parameter int CHUNK_W = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  packet_receiver_if.slave    bus,
  output logic [7:0]          drop_cnt
);

  localparam int N_CHUNK = (MSG_W + CHUNK_W - 1) / CHUNK_W;
  localparam int IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam int TMR_W   = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CHUNK - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t             state_r;
  logic               s1_r;
  logic               s2_r;
  logic [IDX_W-1:0]   idx_r;
  logic [TMR_W-1:0]   timer_r;
  logic [MSG_W-1:0]   buf_r;
  logic               ack_r;
  logic [MSG_W-1:0]   data_r;
  logic               valid_r;
  logic [7:0]         drop_r;

  // Writes chunk d into slot k of the assembly buffer. Bits of the final
  // chunk that fall beyond MSG_W are simply never written, which is how the
  // unused upper bits of the last chunk get ignored.
  function automatic logic [MSG_W-1:0] insert_chunk(
    input logic [MSG_W-1:0]   b,
    input logic [IDX_W-1:0]   k,
    input logic [CHUNK_W-1:0] d
  );
    logic [MSG_W-1:0] r;
    r = b;
    for (int i = 0; i < N_CHUNK; i++) begin
      for (int j = 0; j < CHUNK_W; j++) begin
        if ((k == IDX_W'(i)) && ((i * CHUNK_W + j) < MSG_W)) begin
          r[i * CHUNK_W + j] = d[j];
        end else begin
          r = r;
        end
      end
    end
    return r;
  endfunction

  // REQ synchroniser, handshake FSM, chunk assembly, commit and timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      idx_r   <= '0;
      timer_r <= '0;
      buf_r   <= '0;
      ack_r   <= 1'b0;
      data_r  <= '0;
      valid_r <= 1'b0;
      drop_r  <= 8'd0;
    end else begin
      s1_r    <= bus.req_in;
      s2_r    <= s1_r;
      valid_r <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (s2_r) begin
            // A capture always beats a timeout expiring on the same cycle.
            buf_r   <= insert_chunk(buf_r, idx_r, bus.data_in);
            timer_r <= '0;
            ack_r   <= 1'b1;
            state_r <= ST_ACK;
          end else if (idx_r == '0) begin
            timer_r <= '0;
          end else if (timer_r == TMR_LAST) begin
            // Sender went quiet mid-packet: drop the partial datagram.
            idx_r   <= '0;
            timer_r <= '0;
            if (drop_r != 8'hFF) begin
              drop_r <= drop_r + 8'd1;
            end else begin
              drop_r <= drop_r;
            end
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end

        ST_ACK: begin
          // No timeout here: REQ is level-held, so wait as long as it takes.
          timer_r <= '0;
          if (!s2_r) begin
            ack_r   <= 1'b0;
            state_r <= ST_RELEASE;
          end else begin
            ack_r   <= 1'b1;
          end
        end

        ST_RELEASE: begin
          timer_r <= '0;
          ack_r   <= 1'b0;
          state_r <= ST_IDLE;
          if (idx_r == IDX_LAST) begin
            data_r  <= buf_r;
            valid_r <= 1'b1;
            idx_r   <= '0;
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
          end
        end

        default: begin
          state_r <= ST_IDLE;
          ack_r   <= 1'b0;
          timer_r <= '0;
          idx_r   <= '0;
        end
      endcase
    end
  end

  assign bus.ack_out  = ack_r;
  assign bus.data_out = data_r;
  assign bus.valid    = valid_r;
  assign drop_cnt     = drop_r;

endmodule

// File: tb/tb_packet_receiver.sv
module tb_packet_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] drop_cnt;
  logic [7:0] drop_cnt2;

  always #5 clk = ~clk;

  packet_receiver_if #(.MSG_W(64), .CHUNK_W(6)) bus  ();
  packet_receiver_if #(.MSG_W(64), .CHUNK_W(6)) bus2 ();

  packet_receiver #(.MSG_W(64), .CHUNK_W(6), .TIMEOUT(1024)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );

  // Short-timeout instance used only to exercise drop counter saturation.
  packet_receiver #(.MSG_W(64), .CHUNK_W(6), .TIMEOUT(8)) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus2),
    .drop_cnt (drop_cnt2)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  int          ack_rises  = 0;
  int          valid_cnt  = 0;
  logic        ack_prev   = 1'b0;
  logic        valid_prev = 1'b0;
  logic        dbl_valid  = 1'b0;
  logic [63:0] vq[$];
  int          lat_up0;
  int          lat_dn0;

  // Output monitor: ACK rising edges, valid pulses and committed datagrams.
  always @(negedge clk) begin
    ack_prev   <= bus.ack_out;
    valid_prev <= bus.valid;
    if (bus.ack_out === 1'b1 && ack_prev !== 1'b1) ack_rises <= ack_rises + 1;
    if (bus.valid === 1'b1) begin
      valid_cnt <= valid_cnt + 1;
      vq.push_back(bus.data_out);
      if (valid_prev === 1'b1) dbl_valid <= 1'b1;
    end
  end

  // One 4-phase transfer on the main link; called and returns at a negedge.
  task automatic send_chunk(input logic [5:0] d, output int lat_up, output int lat_dn);
    int n;
    bus.data_in = d;
    bus.req_in  = 1'b1;
    for (n = 0; n < 50 && bus.ack_out !== 1'b1; n++) @(negedge clk);
    lat_up = n;
    if (bus.ack_out !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL ack_rise_timeout: ack_out=%b required 1 within 50 cycles", bus.ack_out);
    end
    bus.req_in = 1'b0;
    for (n = 0; n < 50 && bus.ack_out !== 1'b0; n++) @(negedge clk);
    lat_dn = n;
    if (bus.ack_out !== 1'b0) begin
      tests_run++; tests_failed++;
      $display("FAIL ack_fall_timeout: ack_out=%b required 0 within 50 cycles", bus.ack_out);
    end
  endtask

  task automatic send_packet(input logic [63:0] m, input logic ovr, input logic [5:0] last);
    logic [65:0] pad;
    logic [5:0]  c;
    int          a, b;
    pad = {2'b00, m};
    for (int k = 0; k < 11; k++) begin
      c = pad[k*6 +: 6];
      if (k == 10 && ovr) c = last;
      send_chunk(c, a, b);
      if (k == 0) begin
        lat_up0 = a;
        lat_dn0 = b;
      end
    end
  endtask

  task automatic sat_chunk();
    int n;
    bus2.data_in = 6'h15;
    bus2.req_in  = 1'b1;
    for (n = 0; n < 50 && bus2.ack_out !== 1'b1; n++) @(negedge clk);
    if (bus2.ack_out !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL sat_ack_rise_timeout: ack_out=%b required 1", bus2.ack_out);
    end
    bus2.req_in = 1'b0;
    for (n = 0; n < 50 && bus2.ack_out !== 1'b0; n++) @(negedge clk);
    if (bus2.ack_out !== 1'b0) begin
      tests_run++; tests_failed++;
      $display("FAIL sat_ack_fall_timeout: ack_out=%b required 0", bus2.ack_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.req_in = (i % 2 == 0);
      @(negedge clk);
      tests_run++;
      if (bus.ack_out !== 1'b0 || bus.valid !== 1'b0 || bus.data_out !== 64'h0 || drop_cnt !== 8'd0) begin
        tests_failed++;
        $display("FAIL reset_hold: ack=%b valid=%b data=%h drop=%0d required 0/0/0/0",
                 bus.ack_out, bus.valid, bus.data_out, drop_cnt);
      end
    end
    bus.req_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int ab, vb;
    ab = ack_rises; vb = valid_cnt;
    send_packet(64'h0123456789ABCDEF, 1'b0, 6'h00);
    repeat (3) @(negedge clk);
    tests_run++;
    if (ack_rises - ab !== 11) begin
      tests_failed++; $display("FAIL single_ack_pulses: got %0d required 11", ack_rises - ab);
    end
    tests_run++;
    if (valid_cnt - vb !== 1) begin
      tests_failed++; $display("FAIL single_valid_pulses: got %0d required 1", valid_cnt - vb);
    end
    tests_run++;
    if (bus.data_out !== 64'h0123456789ABCDEF) begin
      tests_failed++; $display("FAIL single_data: got %h required 0123456789abcdef", bus.data_out);
    end
    tests_run++;
    if (lat_up0 !== 3) begin
      tests_failed++; $display("FAIL ack_rise_latency: got %0d edges required 3", lat_up0);
    end
    tests_run++;
    if (lat_dn0 !== 3) begin
      tests_failed++; $display("FAIL ack_fall_latency: got %0d edges required 3", lat_dn0);
    end
  endtask

  task automatic test_mask();
    int vb;
    vb = valid_cnt;
    send_packet(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6'h3F);
    @(negedge clk);
    tests_run++;
    if (bus.data_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      tests_failed++; $display("FAIL mask_3f: got %h required ffffffffffffffff", bus.data_out);
    end
    send_packet(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6'h0F);
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.data_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      tests_failed++; $display("FAIL mask_0f: got %h required ffffffffffffffff", bus.data_out);
    end
    tests_run++;
    if (valid_cnt - vb !== 2) begin
      tests_failed++; $display("FAIL mask_valid_pulses: got %0d required 2", valid_cnt - vb);
    end
  endtask

  task automatic test_timeout();
    int vb, a, b;
    vb = valid_cnt;
    for (int k = 0; k < 5; k++) send_chunk(6'(k + 1), a, b);
    // Timer starts at the RELEASE edge; expiry lands one edge after this wait.
    repeat (1024) @(negedge clk);
    tests_run++;
    if (drop_cnt !== 8'd0) begin
      tests_failed++; $display("FAIL timeout_early: drop_cnt=%0d required 0", drop_cnt);
    end
    @(negedge clk);
    tests_run++;
    if (drop_cnt !== 8'd1) begin
      tests_failed++; $display("FAIL timeout_fire: drop_cnt=%0d required 1", drop_cnt);
    end
    send_packet(64'hA5A5A5A5A5A5A5A5, 1'b0, 6'h00);
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.data_out !== 64'hA5A5A5A5A5A5A5A5) begin
      tests_failed++; $display("FAIL timeout_data: got %h required a5a5a5a5a5a5a5a5", bus.data_out);
    end
    tests_run++;
    if (valid_cnt - vb !== 1 || drop_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL timeout_after: valid=%0d drop=%0d required 1/1", valid_cnt - vb, drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int vb, a, b, n;
    for (int k = 0; k < 7; k++) send_chunk(6'h2A, a, b);
    bus.data_in = 6'h11;
    bus.req_in  = 1'b1;
    for (n = 0; n < 50 && bus.ack_out !== 1'b1; n++) @(negedge clk);
    tests_run++;
    if (bus.ack_out !== 1'b1) begin
      tests_failed++; $display("FAIL mid_ack_high: ack_out=%b required 1", bus.ack_out);
    end
    rst = 1'b0;
    bus.req_in = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.ack_out !== 1'b0 || bus.data_out !== 64'h0 || drop_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: ack=%b data=%h drop=%0d required 0/0/0", bus.ack_out, bus.data_out, drop_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vb = valid_cnt;
    send_packet(64'h1, 1'b0, 6'h00);
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.data_out !== 64'h1 || drop_cnt !== 8'd0 || valid_cnt - vb !== 1) begin
      tests_failed++;
      $display("FAIL mid_fresh: data=%h drop=%0d valid=%0d required 1/0/1", bus.data_out, drop_cnt, valid_cnt - vb);
    end
  endtask

  task automatic test_back_to_back();
    int vb, qs;
    vb = valid_cnt; qs = vq.size();
    send_packet(64'h1111_1111_1111_1111, 1'b0, 6'h00);
    send_packet(64'h2222_2222_2222_2222, 1'b0, 6'h00);
    repeat (3) @(negedge clk);
    tests_run++;
    if (valid_cnt - vb !== 2 || vq.size() < qs + 2) begin
      tests_failed++; $display("FAIL b2b_valid_pulses: got %0d required 2", valid_cnt - vb);
    end else begin
      tests_run++;
      if (vq[qs] !== 64'h1111_1111_1111_1111 || vq[qs+1] !== 64'h2222_2222_2222_2222) begin
        tests_failed++;
        $display("FAIL b2b_sequence: got %h,%h required 1111111111111111,2222222222222222", vq[qs], vq[qs+1]);
      end
    end
    tests_run++;
    if (dbl_valid !== 1'b0 || drop_cnt !== 8'd0) begin
      tests_failed++; $display("FAIL b2b_misc: dbl_valid=%b drop=%0d required 0/0", dbl_valid, drop_cnt);
    end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 300; i++) begin
      sat_chunk();
      repeat (12) @(negedge clk);
      if (i == 1 || i == 255 || i == 300) begin
        tests_run++;
        if (drop_cnt2 !== ((i == 1) ? 8'd1 : 8'd255)) begin
          tests_failed++;
          $display("FAIL sat_drop_%0d: got %0d required %0d", i, drop_cnt2, (i == 1) ? 1 : 255);
        end
      end
    end
  endtask

  initial begin
    rst          = 1'b0;
    bus.req_in   = 1'b0;
    bus.data_in  = 6'h00;
    bus2.req_in  = 1'b0;
    bus2.data_in = 6'h00;
    test_reset();
    test_single();
    test_mask();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/packet_receiver.md
Name: packet_receiver

Overview:
- Receive side of the inter-board link. Consumes the 6-bit, 4-phase REQ/ACK chunk stream produced by the link sender on the central board.
- Reassembles the chunks into one full datagram and presents it with a one-cycle valid strobe to the downstream output interface (VGA renderer).
- Synchronises the asynchronous REQ line and recovers framing after a partial or broken packet.

Parameters:
- MSG_W, 64, datagram width in bits.
- CHUNK_W, 6, link data-bus width in bits.
- TIMEOUT, 1024, idle cycles allowed mid-packet before the partial packet is discarded.
- Derived N_CHUNK = ceil(MSG_W/CHUNK_W); 11 at defaults.

Ports:
- clk  input  1  system clock; the block's only clock.
- rst  input  1  reset, synchronous and active-low.
- req_in  input  1  link REQ from sender; asynchronous to clk.
- data_in  input  CHUNK_W  link data; stable from before req_in rises until ack_out rises.
- ack_out  output  1  link ACK to sender; registered.
- data_out  output  MSG_W  last complete datagram; held until the next commit.
- valid  output  1  one-cycle pulse on the cycle data_out updates.
- drop_cnt  output  8  saturating count of discarded partial packets.

Behaviour:
- Reset (rst==0 at posedge clk):
  - ack_out=0, valid=0, data_out=0, drop_cnt=0.
  - Chunk index=0, timer=0, sync flops=0, FSM=IDLE.
  - Applies mid-handshake too: ACK drops immediately and the partial assembly buffer is discarded without incrementing drop_cnt.
- REQ sync: 2-flop synchroniser req_in→s1→s2. FSM uses s2 only. data_in is not synchronised; it is captured only when s2==1.
- FSM:
  - IDLE, ack_out=0: if s2==1, write data_in into buffer slot idx and go to ACK.
  - ACK, ack_out=1: wait until s2==0, then go to RELEASE.
  - RELEASE, ack_out=0, one cycle:
    - If idx==N_CHUNK-1: data_out<=buffer (including this chunk), valid=1 for this cycle, idx<=0.
    - Else idx<=idx+1.
    - Next state IDLE.
- Chunk order is LSB-first: chunk k fills bits [k*CHUNK_W +: CHUNK_W]. For the final chunk, only the low MSG_W-(N_CHUNK-1)*CHUNK_W bits are used (4 at defaults); its upper bits are ignored.
- Latency:
  - req_in seen high at edge t → s2 high after edge t+1 → capture and ack_out=1 after edge t+2.
  - req_in low at edge u → ack_out=0 after edge u+2.
  - Final RELEASE → valid and data_out after the same edge.
- Buffer: separate from data_out. data_out never shows a partial datagram.
- Timeout (framing recovery):
  - In IDLE with idx!=0, timer increments each cycle. It clears on any s2==1 and whenever idx==0.
  - When timer reaches TIMEOUT-1 in IDLE: idx<=0, timer<=0, drop_cnt<=drop_cnt+1, saturating at 255. data_out and valid are unaffected.
  - No timeout runs in ACK; the block waits indefinitely for REQ low.
- Simultaneous events:
  - Timeout expiry on the same cycle s2 rises: the capture wins; no drop, idx unchanged.
  - A rise of s2 during RELEASE is handled on the next IDLE cycle; nothing is lost because REQ is level-held.
- Back-to-back packets need no gap. Chunk 0 of the next packet may be captured on the cycle after the final RELEASE.
- valid is never asserted for two consecutive cycles. Minimum spacing between valids is N_CHUNK×(4-phase round trip).

Test Plan:
- Reset hold: rst=0 for 5 cycles while req_in toggles → ack_out, valid, data_out, drop_cnt all stay 0.
- Single packet 0x0123456789ABCDEF, 11 chunks LSB-first (first chunk 0x2F, last chunk 0x0), sender model obeying 4-phase → exactly 11 ack_out pulses, one valid pulse, data_out=0x0123456789ABCDEF. Check ack_out rises exactly 3 edges after req_in is first sampled high.
- Final chunk upper-bit masking: packet 0xFFFF_FFFF_FFFF_FFFF with final chunk driven as 0x3F → data_out=0xFFFFFFFFFFFFFFFF, no X; repeat with 0x0F → same result.
- Timeout recovery: send 5 chunks, idle 1024 cycles, then a full packet 0xA5A5A5A5A5A5A5A5 → drop_cnt=1, one valid, data_out=0xA5A5A5A5A5A5A5A5.
- Reset mid-handshake: assert rst while ack_out=1 during chunk 7 → ack_out=0 next edge. A fresh full packet 0x1 then yields data_out=0x1 and drop_cnt=0.
- Back-to-back packets 0x1111…1 then 0x2222…2 with zero idle → two valid pulses, data_out sequence correct, drop_cnt=0; drop_cnt saturates at 255 after 300 forced timeouts.
